// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - shared lamp, symbol, phase and duration constants for the light bus
//
// Purpose: common definitions used by the light controller and its monitor.
//   LAMP_*          one-hot lamp codes {red,yellow,green}
//   SYM_*           decoded two-road bus symbols
//   P0..P5          cycle phases
//   DEF_*_CYC       default phase durations in samples
//   phase_sym()     bus symbol expected during a phase
//   next_phase()    successor phase, wrapping P5 -> P0
package tl_pkg;

  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;

  localparam logic [2:0] SYM_AG  = 3'd0;
  localparam logic [2:0] SYM_AY  = 3'd1;
  localparam logic [2:0] SYM_RR  = 3'd2;
  localparam logic [2:0] SYM_BG  = 3'd3;
  localparam logic [2:0] SYM_BY  = 3'd4;
  localparam logic [2:0] SYM_BAD = 3'd5;

  localparam logic [2:0] P0 = 3'd0;
  localparam logic [2:0] P1 = 3'd1;
  localparam logic [2:0] P2 = 3'd2;
  localparam logic [2:0] P3 = 3'd3;
  localparam logic [2:0] P4 = 3'd4;
  localparam logic [2:0] P5 = 3'd5;

  localparam int DEF_GREEN_CYC  = 6;
  localparam int DEF_YELLOW_CYC = 2;
  localparam int DEF_ALLRED_CYC = 2;

  function automatic logic [2:0] phase_sym(input logic [2:0] p);
    case (p)
      P0:      phase_sym = SYM_AG;
      P1:      phase_sym = SYM_AY;
      P2:      phase_sym = SYM_RR;
      P3:      phase_sym = SYM_BG;
      P4:      phase_sym = SYM_BY;
      P5:      phase_sym = SYM_RR;
      default: phase_sym = SYM_BAD;
    endcase
  endfunction

  function automatic logic [2:0] next_phase(input logic [2:0] p);
    next_phase = (p == P5) ? P0 : p + 3'd1;
  endfunction

endpackage

// File: rtl/tl_bus_decode.sv
// rtl/tl_bus_decode.sv - combinational decoder of the two-road light bus
//
// Purpose: map {light_A, light_B} to one bus symbol plus error indications.
// Ports:
//   light_A   in  3  road A lamps (one-hot {red,yellow,green})
//   light_B   in  3  road B lamps
//   sym       out 3  SYM_AG/AY/RR/BG/BY, or SYM_BAD on any error
//   code_err  out 1  either lamp word is not a legal one-hot code
//   conflict  out 1  neither road shows red
module tl_bus_decode
  import tl_pkg::*;
(
  input  logic [2:0] light_A,
  input  logic [2:0] light_B,
  output logic [2:0] sym,
  output logic       code_err,
  output logic       conflict
);

  function automatic logic legal(input logic [2:0] l);
    legal = (l == LAMP_GREEN) || (l == LAMP_YELLOW) || (l == LAMP_RED);
  endfunction

  always_comb begin
    code_err = !legal(light_A) || !legal(light_B);
    // Any non-red word counts as "showing", so an illegal word can also conflict.
    conflict = (light_A != LAMP_RED) && (light_B != LAMP_RED);
    sym      = SYM_BAD;
    if (!code_err && !conflict) begin
      // Here at least one road is red, so only five combinations remain.
      if (light_B == LAMP_RED) begin
        case (light_A)
          LAMP_GREEN:  sym = SYM_AG;
          LAMP_YELLOW: sym = SYM_AY;
          default:     sym = SYM_RR;
        endcase
      end else begin
        sym = (light_B == LAMP_GREEN) ? SYM_BG : SYM_BY;
      end
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - lock-on checker for the 6-phase two-road light cycle
//
// Purpose: track the light bus phase by phase and flag code, conflict, order and dwell errors.
// Ports:
//   clk, rst        clock (rising) and asynchronous active-high reset
//   en              sample enable; 0 freezes all tracking state
//   clr             synchronous clear of err_* flags and err_count
//   light_A/B       road lamp words
//   phase           tracked phase 0..5
//   locked          1 while tracking the cycle
//   cycle_done      one-clock pulse on a legal P5->P0 advance
//   err_code/err_conflict/err_seq/err_timing  sticky error flags
//   err_count       erroneous-sample count, saturating
module traffic_light_monitor
  import tl_pkg::*;
#(
  parameter int GREEN_CYC  = DEF_GREEN_CYC,
  parameter int YELLOW_CYC = DEF_YELLOW_CYC,
  parameter int ALLRED_CYC = DEF_ALLRED_CYC,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [2:0]       light_A,
  input  logic [2:0]       light_B,
  output logic [2:0]       phase,
  output logic             locked,
  output logic             cycle_done,
  output logic             err_code,
  output logic             err_conflict,
  output logic             err_seq,
  output logic             err_timing,
  output logic [ERR_W-1:0] err_count
);

  localparam int MAX_GY = (GREEN_CYC > YELLOW_CYC) ? GREEN_CYC : YELLOW_CYC;
  localparam int MAX_L  = (MAX_GY > ALLRED_CYC) ? MAX_GY : ALLRED_CYC;
  localparam int DW     = $clog2(MAX_L) + 1;

  localparam logic [0:0] ST_SYNC  = 1'b0;
  localparam logic [0:0] ST_TRACK = 1'b1;

  function automatic logic [DW-1:0] phase_len(input logic [2:0] p);
    case (p)
      P0, P3:  phase_len = DW'(GREEN_CYC);
      P1, P4:  phase_len = DW'(YELLOW_CYC);
      default: phase_len = DW'(ALLRED_CYC);
    endcase
  endfunction

  logic [2:0]    sym;
  logic          code_err;
  logic          conflict;

  logic [0:0]    state, state_n;
  logic [2:0]    phase_n;
  logic [DW-1:0] dwell, dwell_n;
  logic          first;
  logic [2:0]    prev;
  logic          done_n;
  logic          seq_e, tim_e;
  logic          code_v, confl_v, seq_v, tim_v, any_err;

  tl_bus_decode u_decode (
    .light_A  (light_A),
    .light_B  (light_B),
    .sym      (sym),
    .code_err (code_err),
    .conflict (conflict)
  );

  always_comb begin
    state_n = state;
    phase_n = phase;
    dwell_n = dwell;
    done_n  = 1'b0;
    seq_e   = 1'b0;
    tim_e   = 1'b0;
    if (state == ST_SYNC) begin
      // Lock only on an AG start edge; after the very first sample that means RR->AG.
      if (sym == SYM_AG && (first || prev == SYM_RR)) begin
        state_n = ST_TRACK;
        phase_n = P0;
        dwell_n = DW'(1);
      end
    end else begin
      if (sym == phase_sym(phase)) begin
        if (dwell < phase_len(phase)) dwell_n = dwell + DW'(1);
        else                          tim_e   = 1'b1;
      end else if (sym == phase_sym(next_phase(phase))) begin
        if (dwell < phase_len(phase)) begin
          tim_e = 1'b1;
        end else begin
          phase_n = next_phase(phase);
          dwell_n = DW'(1);
          done_n  = (phase == P5);
        end
      end else begin
        seq_e = 1'b1;
      end
      if (seq_e || tim_e) begin
        state_n = ST_SYNC;
        phase_n = P0;
        dwell_n = '0;
      end
    end
  end

  // Error contributions of this sample; nothing is checked while frozen.
  assign code_v  = en & code_err;
  assign confl_v = en & conflict;
  assign seq_v   = en & seq_e;
  assign tim_v   = en & tim_e;
  assign any_err = code_v | confl_v | seq_v | tim_v;

  assign locked = (state == ST_TRACK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_SYNC;
      phase        <= P0;
      dwell        <= '0;
      first        <= 1'b1;
      prev         <= SYM_RR;
      cycle_done   <= 1'b0;
      err_code     <= 1'b0;
      err_conflict <= 1'b0;
      err_seq      <= 1'b0;
      err_timing   <= 1'b0;
      err_count    <= '0;
    end else begin
      if (en) begin
        state      <= state_n;
        phase      <= phase_n;
        dwell      <= dwell_n;
        first      <= 1'b0;
        prev       <= sym;
        cycle_done <= done_n;
      end else begin
        cycle_done <= 1'b0;
      end
      // clr discards history but the current sample's errors still land.
      if (clr) begin
        err_code     <= code_v;
        err_conflict <= confl_v;
        err_seq      <= seq_v;
        err_timing   <= tim_v;
        err_count    <= any_err ? ERR_W'(1) : '0;
      end else begin
        err_code     <= err_code     | code_v;
        err_conflict <= err_conflict | confl_v;
        err_seq      <= err_seq      | seq_v;
        err_timing   <= err_timing   | tim_v;
        if (any_err && err_count != '1) err_count <= err_count + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - directed self-checking bench for traffic_light_monitor
module tb_traffic_light_monitor;
  import tl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic       clr = 1'b0;
  logic [2:0] light_A = LAMP_RED;
  logic [2:0] light_B = LAMP_RED;
  logic [2:0] phase;
  logic       locked, cycle_done;
  logic       err_code, err_conflict, err_seq, err_timing;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  traffic_light_monitor #(
    .GREEN_CYC  (6),
    .YELLOW_CYC (2),
    .ALLRED_CYC (2),
    .ERR_W      (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .clr          (clr),
    .light_A      (light_A),
    .light_B      (light_B),
    .phase        (phase),
    .locked       (locked),
    .cycle_done   (cycle_done),
    .err_code     (err_code),
    .err_conflict (err_conflict),
    .err_seq      (err_seq),
    .err_timing   (err_timing),
    .err_count    (err_count)
  );

  // Apply one sample and settle just past the sampling edge.
  task automatic drive(input logic [2:0] a, input logic [2:0] b);
    light_A = a;
    light_B = b;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_sym(input logic [2:0] s);
    case (s)
      SYM_AG:  drive(LAMP_GREEN,  LAMP_RED);
      SYM_AY:  drive(LAMP_YELLOW, LAMP_RED);
      SYM_BG:  drive(LAMP_RED,    LAMP_GREEN);
      SYM_BY:  drive(LAMP_RED,    LAMP_YELLOW);
      default: drive(LAMP_RED,    LAMP_RED);
    endcase
  endtask

  // Controller output for cycle sample k: 6 AG, 2 AY, 2 RR, 6 BG, 2 BY, 2 RR.
  function automatic logic [2:0] sym_at(input int k);
    int m;
    m = k % 20;
    if (m < 6)       sym_at = SYM_AG;
    else if (m < 8)  sym_at = SYM_AY;
    else if (m < 10) sym_at = SYM_RR;
    else if (m < 16) sym_at = SYM_BG;
    else if (m < 18) sym_at = SYM_BY;
    else             sym_at = SYM_RR;
  endfunction

  function automatic logic [2:0] phase_at(input int k);
    int m;
    m = k % 20;
    if (m < 6)       phase_at = 3'd0;
    else if (m < 8)  phase_at = 3'd1;
    else if (m < 10) phase_at = 3'd2;
    else if (m < 16) phase_at = 3'd3;
    else if (m < 18) phase_at = 3'd4;
    else             phase_at = 3'd5;
  endfunction

  task automatic do_reset();
    en  = 1'b1;
    clr = 1'b0;
    light_A = LAMP_RED;
    light_B = LAMP_RED;
    #2;
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) drive_sym(sym_at(k));
    drive(3'b000, 3'b000);
    // Asynchronous assertion away from any edge.
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({phase, locked, cycle_done, err_code, err_conflict, err_seq, err_timing, err_count} !== 16'd0)
      $display("FAIL reset_outputs: got phase=%0d locked=%b done=%b flags=%b%b%b%b count=%0d, expected all zero",
               phase, locked, cycle_done, err_code, err_conflict, err_seq, err_timing, err_count);
    else n_pass++;
    rst = 1'b0;
    drive_sym(SYM_AG);
    n_checks++;
    if (locked !== 1'b1) $display("FAIL reset_first_lock: locked=%b expected 1", locked);
    else n_pass++;
  endtask

  task automatic test_cycle();
    logic exp_done;
    do_reset();
    for (int k = 0; k <= 60; k++) begin
      drive_sym(sym_at(k));
      exp_done = (k > 0) && (k % 20 == 0);
      n_checks++;
      if (cycle_done !== exp_done || phase !== phase_at(k) || locked !== 1'b1)
        $display("FAIL cycle_k%0d: done=%b phase=%0d locked=%b expected done=%b phase=%0d locked=1",
                 k, cycle_done, phase, locked, exp_done, phase_at(k));
      else n_pass++;
    end
    n_checks++;
    if ({err_code, err_conflict, err_seq, err_timing} !== 4'b0000 || err_count !== 8'd0)
      $display("FAIL cycle_no_errors: flags=%b%b%b%b count=%0d expected 0000 and 0",
               err_code, err_conflict, err_seq, err_timing, err_count);
    else n_pass++;
  endtask

  // Continues from the locked P0 state left by test_cycle.
  task automatic test_code_err();
    drive(3'b011, LAMP_RED);
    n_checks++;
    if (err_code !== 1'b1 || err_seq !== 1'b1 || err_conflict !== 1'b0 || err_timing !== 1'b0 ||
        err_count !== 8'd1 || locked !== 1'b0)
      $display("FAIL code_err: code=%b seq=%b confl=%b tim=%b count=%0d locked=%b expected 1 1 0 0 1 0",
               err_code, err_seq, err_conflict, err_timing, err_count, locked);
    else n_pass++;
    drive_sym(SYM_AG);
    n_checks++;
    if (locked !== 1'b0) $display("FAIL code_no_relock_after_bad: locked=%b expected 0", locked);
    else n_pass++;
    drive_sym(SYM_RR);
    drive_sym(SYM_AG);
    n_checks++;
    if (locked !== 1'b1 || phase !== 3'd0 || err_count !== 8'd1)
      $display("FAIL code_relock_rr_ag: locked=%b phase=%0d count=%0d expected 1 0 1", locked, phase, err_count);
    else n_pass++;
  endtask

  task automatic test_conflict();
    do_reset();
    drive(LAMP_GREEN, LAMP_GREEN);
    n_checks++;
    if (err_conflict !== 1'b1 || err_code !== 1'b0 || err_seq !== 1'b0 || err_count !== 8'd1 || locked !== 1'b0)
      $display("FAIL conflict: confl=%b code=%b seq=%b count=%0d locked=%b expected 1 0 0 1 0",
               err_conflict, err_code, err_seq, err_count, locked);
    else n_pass++;
  endtask

  task automatic test_skip_yellow();
    do_reset();
    for (int k = 0; k < 6; k++) drive_sym(SYM_AG);
    n_checks++;
    if (locked !== 1'b1 || err_count !== 8'd0)
      $display("FAIL skip_pre: locked=%b count=%0d expected 1 0", locked, err_count);
    else n_pass++;
    drive_sym(SYM_RR);
    n_checks++;
    if (err_seq !== 1'b1 || err_timing !== 1'b0 || phase !== 3'd0 || locked !== 1'b0 || err_count !== 8'd1)
      $display("FAIL skip_yellow: seq=%b tim=%b phase=%0d locked=%b count=%0d expected 1 0 0 0 1",
               err_seq, err_timing, phase, locked, err_count);
    else n_pass++;
  endtask

  task automatic test_dwell();
    do_reset();
    for (int k = 0; k < 5; k++) drive_sym(SYM_AG);
    drive_sym(SYM_AY);
    n_checks++;
    if (err_timing !== 1'b1 || err_seq !== 1'b0 || locked !== 1'b0 || err_count !== 8'd1)
      $display("FAIL short_green: tim=%b seq=%b locked=%b count=%0d expected 1 0 0 1",
               err_timing, err_seq, locked, err_count);
    else n_pass++;

    do_reset();
    for (int k = 0; k < 6; k++) drive_sym(SYM_AG);
    n_checks++;
    if (err_timing !== 1'b0 || locked !== 1'b1)
      $display("FAIL long_green_6th: tim=%b locked=%b expected 0 1", err_timing, locked);
    else n_pass++;
    drive_sym(SYM_AG);
    n_checks++;
    if (err_timing !== 1'b1 || err_seq !== 1'b0 || locked !== 1'b0 || err_count !== 8'd1)
      $display("FAIL long_green_7th: tim=%b seq=%b locked=%b count=%0d expected 1 0 0 1",
               err_timing, err_seq, locked, err_count);
    else n_pass++;
    drive_sym(SYM_AG);
    n_checks++;
    if (locked !== 1'b0 || err_count !== 8'd1)
      $display("FAIL long_green_no_relock: locked=%b count=%0d expected 0 1", locked, err_count);
    else n_pass++;
  endtask

  task automatic test_saturate_clr();
    do_reset();
    for (int k = 0; k < 254; k++) drive(3'b000, 3'b000);
    n_checks++;
    if (err_count !== 8'd254) $display("FAIL count_254: count=%0d expected 254", err_count);
    else n_pass++;
    for (int k = 0; k < 46; k++) drive(3'b000, 3'b000);
    n_checks++;
    if (err_count !== 8'd255 || err_code !== 1'b1 || err_conflict !== 1'b1)
      $display("FAIL count_saturate: count=%0d code=%b confl=%b expected 255 1 1", err_count, err_code, err_conflict);
    else n_pass++;
    clr = 1'b1;
    drive_sym(SYM_RR);
    clr = 1'b0;
    n_checks++;
    if ({err_code, err_conflict, err_seq, err_timing} !== 4'b0000 || err_count !== 8'd0)
      $display("FAIL clr_plain: flags=%b%b%b%b count=%0d expected 0000 0",
               err_code, err_conflict, err_seq, err_timing, err_count);
    else n_pass++;
    drive(3'b000, 3'b000);
    drive(3'b000, 3'b000);
    clr = 1'b1;
    drive(3'b011, LAMP_RED);
    clr = 1'b0;
    n_checks++;
    if (err_code !== 1'b1 || err_conflict !== 1'b0 || err_count !== 8'd1)
      $display("FAIL clr_with_new_err: code=%b confl=%b count=%0d expected 1 0 1", err_code, err_conflict, err_count);
    else n_pass++;
    en  = 1'b0;
    clr = 1'b1;
    drive(3'b000, 3'b000);
    clr = 1'b0;
    en  = 1'b1;
    n_checks++;
    if (err_code !== 1'b0 || err_count !== 8'd0)
      $display("FAIL clr_while_frozen: code=%b count=%0d expected 0 0", err_code, err_count);
    else n_pass++;
  endtask

  task automatic test_freeze();
    do_reset();
    for (int k = 0; k < 3; k++) drive_sym(sym_at(k));
    en = 1'b0;
    for (int k = 0; k < 10; k++) drive(3'b000, 3'b000);
    n_checks++;
    if (locked !== 1'b1 || phase !== 3'd0 || cycle_done !== 1'b0 || err_count !== 8'd0 || err_code !== 1'b0)
      $display("FAIL freeze_hold: locked=%b phase=%0d done=%b count=%0d code=%b expected 1 0 0 0 0",
               locked, phase, cycle_done, err_count, err_code);
    else n_pass++;
    en = 1'b1;
    for (int k = 3; k < 20; k++) drive_sym(sym_at(k));
    n_checks++;
    if (phase !== 3'd5 || cycle_done !== 1'b0 || locked !== 1'b1)
      $display("FAIL freeze_resume_p5: phase=%0d done=%b locked=%b expected 5 0 1", phase, cycle_done, locked);
    else n_pass++;
    drive_sym(sym_at(20));
    n_checks++;
    if (cycle_done !== 1'b1 || phase !== 3'd0 || err_count !== 8'd0 || err_timing !== 1'b0)
      $display("FAIL freeze_resume_done: done=%b phase=%0d count=%0d tim=%b expected 1 0 0 0",
               cycle_done, phase, err_count, err_timing);
    else n_pass++;
    drive_sym(sym_at(21));
    n_checks++;
    if (cycle_done !== 1'b0) $display("FAIL done_one_clk: done=%b expected 0", cycle_done);
    else n_pass++;
  endtask

  initial begin
    #1;
    test_reset();
    test_cycle();
    test_code_err();
    test_conflict();
    test_skip_yellow();
    test_dwell();
    test_saturate_clr();
    test_freeze();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
